// File: rtl/router_output_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_output_allocator                                                    |
// | Wormhole output allocator: round-robin between packets, credit-gated sends.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module router_output_allocator #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 4,
  localparam int IDX_W            = $clog2(NUM_INPUTS),
  localparam int CRD_W            = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req_valid,
  input  logic [NUM_INPUTS-1:0] req_tail,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  send_out,
  output logic [IDX_W-1:0]      owner_idx,
  output logic                  locked,
  output logic [CRD_W-1:0]      credits,
  output logic                  credit_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [IDX_W:0]   c_num_inputs = (IDX_W + 1)'(NUM_INPUTS);
  localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(NUM_INPUTS - 1);
  localparam logic [CRD_W-1:0] c_depth      = CRD_W'(FLIT_BUFFER_DEPTH);

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic [CRD_W-1:0]      r_credits;
  logic                  r_credit_err;
  logic [NUM_INPUTS-1:0] w_grant;
  logic                  w_found;
  logic [IDX_W-1:0]      w_winner;
  logic [IDX_W:0]        w_cand;
  logic                  w_can_send;
  logic                  w_send;

  // Pointer advance stays inside 0..NUM_INPUTS-1 even when that is not a power of two.
  function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] idx);
    return (idx == c_last_idx) ? '0 : idx + 1'b1;
  endfunction

  // Grants are forced low while reset is asserted so nothing is consumed during reset.
  assign w_can_send = rst_n && (r_credits != '0);

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
      if (w_cand >= c_num_inputs) w_cand = w_cand - c_num_inputs;
      if (!w_found && req_valid[w_cand[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant     = '0;
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        if (w_found && w_can_send) begin
          w_grant[w_winner] = 1'b1;
          w_owner_nxt       = w_winner;
          if (req_tail[w_winner]) w_rr_nxt = f_inc(w_winner);
          else                    w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // Bubbles and credit starvation simply hold the lock.
        if (req_valid[r_owner] && w_can_send) begin
          w_grant[r_owner] = 1'b1;
          if (req_tail[r_owner]) begin
            w_state_nxt = IDLE;
            w_rr_nxt    = f_inc(r_owner);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_send = |w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_credits    <= c_depth;
      r_credit_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      if (w_send && !credit_in) begin
        r_credits <= r_credits - 1'b1;
      end else if (credit_in && !w_send) begin
        if (r_credits == c_depth) r_credit_err <= 1'b1;
        else                      r_credits    <= r_credits + 1'b1;
      end
    end
  end

  assign grant      = w_grant;
  assign send_out   = w_send;
  assign owner_idx  = r_owner;
  assign locked     = (r_state == LOCKED);
  assign credits    = r_credits;
  assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_router_output_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_router_output_allocator                                                 |
// | Directed self-checking bench for the wormhole output allocator.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_router_output_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req_valid;
  logic [4:0] req_tail;
  logic       credit_in;
  logic [4:0] grant;
  logic       send_out;
  logic [2:0] owner_idx;
  logic       locked;
  logic [2:0] credits;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  router_output_allocator #(
    .NUM_INPUTS       (5),
    .FLIT_BUFFER_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_tail  (req_tail),
    .credit_in (credit_in),
    .grant     (grant),
    .send_out  (send_out),
    .owner_idx (owner_idx),
    .locked    (locked),
    .credits   (credits),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  // Invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    logic [4:0] owner_oh;
    owner_oh = 5'b00001 << owner_idx;
    checks++;
    if (!$onehot0(grant)) begin
      errors++;
      $display("FAIL inv_onehot0 grant=%b", grant);
    end
    checks++;
    if (send_out !== (|grant)) begin
      errors++;
      $display("FAIL inv_send_out send_out=%b grant=%b", send_out, grant);
    end
    checks++;
    if (credits > 3'd4) begin
      errors++;
      $display("FAIL inv_credits_max credits=%0d max=4", credits);
    end
    checks++;
    if (locked && send_out && (grant !== owner_oh)) begin
      errors++;
      $display("FAIL inv_locked_owner grant=%b owner_idx=%0d", grant, owner_idx);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    req_tail  = '0;
    credit_in = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 5'b11111;
    req_tail  = 5'b11111;
    credit_in = 1'b0;
    tick();
    #1;
    checks++;
    if ({grant, send_out, locked, owner_idx, credits, credit_err} !== {5'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got grant=%b send=%b locked=%b owner=%0d credits=%0d err=%b want 00000 0 0 0 4 0",
               grant, send_out, locked, owner_idx, credits, credit_err);
    end
    req_valid = '0;
    req_tail  = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g [4] = '{5'b00010, 5'b00100, 5'b00010, 5'b00100};
    reset_dut();
    req_valid = 5'b00110;
    req_tail  = 5'b00110;
    credit_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (grant !== exp_g[i] || credits !== 3'd4) begin
        errors++;
        $display("FAIL rr_cycle%0d grant=%b credits=%0d want grant=%b credits=4", i, grant, credits, exp_g[i]);
      end
      tick();
    end
    req_valid = '0;
    credit_in = 1'b0;
    #1;
    checks++;
    if (owner_idx !== 3'd2 || credits !== 3'd4 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL rr_end owner=%0d credits=%0d err=%b want 2 4 0", owner_idx, credits, credit_err);
    end
    tick();
  endtask

  task automatic test_wormhole();
    logic [4:0] tails [4] = '{5'b01000, 5'b01000, 5'b01001, 5'b01000};
    logic [4:0] reqs  [4] = '{5'b01001, 5'b01001, 5'b01001, 5'b01000};
    logic [4:0] exp_g [4] = '{5'b00001, 5'b00001, 5'b00001, 5'b01000};
    logic       exp_l [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_c [4] = '{3'd4, 3'd3, 3'd2, 3'd1};
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      req_valid = reqs[i];
      req_tail  = tails[i];
      #1;
      checks++;
      if (grant !== exp_g[i] || locked !== exp_l[i] || credits !== exp_c[i]) begin
        errors++;
        $display("FAIL worm_cycle%0d grant=%b locked=%b credits=%0d want %b %b %0d",
                 i, grant, locked, credits, exp_g[i], exp_l[i], exp_c[i]);
      end
      tick();
    end
    req_valid = '0;
    #1;
    checks++;
    if (owner_idx !== 3'd3 || locked !== 1'b0 || credits !== 3'd0) begin
      errors++;
      $display("FAIL worm_end owner=%0d locked=%b credits=%0d want 3 0 0", owner_idx, locked, credits);
    end
    tick();
  endtask

  task automatic test_credit_starve();
    logic [4:0] exp_g [9] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b0, 5'b0, 5'b0, 5'b00100, 5'b0};
    logic [2:0] exp_c [9] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0};
    logic       crd   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    reset_dut();
    req_valid = 5'b00100;
    req_tail  = 5'b00100;
    for (int i = 0; i < 9; i++) begin
      credit_in = crd[i];
      #1;
      checks++;
      if (grant !== exp_g[i] || credits !== exp_c[i]) begin
        errors++;
        $display("FAIL starve_cycle%0d grant=%b credits=%0d want %b %0d", i, grant, credits, exp_g[i], exp_c[i]);
      end
      tick();
    end
    req_valid = '0;
    credit_in = 1'b0;
  endtask

  task automatic test_bubble();
    logic [4:0] reqs  [5] = '{5'b10000, 5'b00011, 5'b00011, 5'b10011, 5'b00011};
    logic [4:0] tails [5] = '{5'b00000, 5'b00011, 5'b00011, 5'b10000, 5'b00011};
    logic [4:0] exp_g [5] = '{5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00001};
    logic       exp_l [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_c [5] = '{3'd4, 3'd3, 3'd3, 3'd3, 3'd2};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      req_valid = reqs[i];
      req_tail  = tails[i];
      #1;
      checks++;
      if (grant !== exp_g[i] || locked !== exp_l[i] || credits !== exp_c[i]) begin
        errors++;
        $display("FAIL bubble_cycle%0d grant=%b locked=%b credits=%0d want %b %b %0d",
                 i, grant, locked, credits, exp_g[i], exp_l[i], exp_c[i]);
      end
      tick();
    end
    req_valid = '0;
    req_tail  = '0;
    #1;
    checks++;
    if (owner_idx !== 3'd0 || credits !== 3'd1) begin
      errors++;
      $display("FAIL bubble_end owner=%0d credits=%0d want 0 1", owner_idx, credits);
    end
    tick();
  endtask

  task automatic test_credit_err();
    reset_dut();
    credit_in = 1'b1;
    #1;
    checks++;
    if (credit_err !== 1'b0 || grant !== 5'b0) begin
      errors++;
      $display("FAIL cerr_before err=%b grant=%b want 0 00000", credit_err, grant);
    end
    tick();
    credit_in = 1'b0;
    tick();
    checks++;
    if (credits !== 3'd4 || credit_err !== 1'b1) begin
      errors++;
      $display("FAIL cerr_saturate credits=%0d err=%b want 4 1", credits, credit_err);
    end
    req_valid = 5'b00001;
    req_tail  = 5'b00001;
    tick();
    tick();
    checks++;
    if (credits !== 3'd2) begin
      errors++;
      $display("FAIL cerr_two_sends credits=%0d want 2", credits);
    end
    credit_in = 1'b1;
    #1;
    checks++;
    if (grant !== 5'b00001) begin
      errors++;
      $display("FAIL cerr_both_grant grant=%b want 00001", grant);
    end
    tick();
    req_valid = '0;
    credit_in = 1'b0;
    #1;
    checks++;
    if (credits !== 3'd2 || credit_err !== 1'b1) begin
      errors++;
      $display("FAIL cerr_both credits=%0d err=%b want 2 1", credits, credit_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    reset_dut();
    req_valid = 5'b00010;
    req_tail  = 5'b00000;
    repeat (3) tick();
    checks++;
    if (locked !== 1'b1 || credits !== 3'd1) begin
      errors++;
      $display("FAIL midrst_setup locked=%b credits=%0d want 1 1", locked, credits);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (credits !== 3'd4 || locked !== 1'b0 || grant !== 5'b0 || send_out !== 1'b0 || owner_idx !== 3'd0) begin
      errors++;
      $display("FAIL midrst_async credits=%0d locked=%b grant=%b send=%b owner=%0d want 4 0 00000 0 0",
               credits, locked, grant, send_out, owner_idx);
    end
    tick();
    checks++;
    if (grant !== 5'b0 || credits !== 3'd4) begin
      errors++;
      $display("FAIL midrst_held grant=%b credits=%0d want 00000 4", grant, credits);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_tail  = '0;
    credit_in = 1'b0;
    #1;
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credit_starve();
    test_bubble();
    test_credit_err();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
